adder_share_arbiter: RTL and testbench
======================================

# adder_share_arbiter

Round-robin arbiter and sequencer that time-shares one WIDTH-bit adder datapath among NUM_REQ requesters over a valid/ready handshake. The winning request's operands are added in the same cycle the request is accepted. The sum, carry and requester ID are captured in a single registered response slot, and each result carries the ID of the requester it belongs to. The block sits between address/offset generators (PC increment, branch target, load/store address) and a single shared adder instance in the datapath.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits
- NUM_REQ, 4, number of requesters; legal range 2..8
- IDW, $clog2(NUM_REQ), requester-ID width (derived, not overridden)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept strobe, at most one bit high
- req_a  in  NUM_REQ*WIDTH  packed SrcA operands; requester i uses slice [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  packed SrcB operands, same packing
- req_sub  in  NUM_REQ  per-requester subtract select; see Configuration
- resp_valid  out  1  response slot occupied
- resp_ready  in  1  consumer accepts the response
- resp_id  out  IDW  index of the requester that produced the response
- resp_result  out  WIDTH  registered Result
- resp_carry  out  1  registered carry-out
- op_count  out  16  number of accepted operations, wraps 0xFFFF→0x0000

## Operation
- Round-robin pointer ptr (IDW bits) marks the highest-priority requester. Search order is ptr, ptr+1, …, wrapping modulo NUM_REQ. The first index with req_valid=1 is the grant.
- accept = grant exists AND (resp_valid=0 OR resp_ready=1).
- req_ready = one-hot(grant) when accept, else all zero. It is combinational from req_valid, resp_valid, resp_ready and ptr.
- On accept, at the clock edge:
  - resp_result ← sum[WIDTH-1:0]
  - resp_carry ← sum[WIDTH]
  - resp_id ← grant
  - resp_valid ← 1
  - ptr ← (grant+1) mod NUM_REQ
  - op_count ← op_count+1
- No accept and resp_valid=1 and resp_ready=1: resp_valid ← 0. Data registers hold their last values.
- No accept and resp_ready=0: all state holds.
- Sum is computed at WIDTH+1 bits: {1'b0,A} + {1'b0,B}. Overflow past the carry bit is discarded.
- Requesters must hold req_valid, req_a, req_b and req_sub stable until they see req_ready. The arbiter does not depend on this for correctness, but results are unspecified if the operands change while the request is pending.
- Operation-level view: slot FSM with two states.
  - EMPTY → FULL on accept.
  - FULL → FULL on accept with resp_ready=1 (back-to-back).
  - FULL → EMPTY on resp_ready=1 with no accept.
  - FULL holds while resp_ready=0.

## Timing
- Reset values: resp_valid=0, resp_id=0, resp_result=0, resp_carry=0, op_count=0, ptr=0, req_ready=0.
- Latency: a request accepted in cycle N appears on resp_* in cycle N+1.
- Throughput: one operation per cycle while resp_ready=1 and any requester is pending.
- Backpressure: with resp_valid=1 and resp_ready=0, req_ready is all zero and the response is held unchanged.
- Fairness: a continuously pending requester is granted within NUM_REQ accepts.
- Single requester: that requester is granted every accept cycle.
- Reset asserted mid-operation:
  - The pending response is dropped and the outputs return to their reset values on the next edge.
  - req_ready is 0 in every cycle in which rst=1.
  - Requests in flight must be re-presented after reset.
- op_count wraps silently at 0xFFFF.

## Configuration
- ADDER_ARB_SUB_EN defined:
  - req_sub[i]=1 computes A + ~B + 1, i.e. A−B.
  - resp_carry=1 means no borrow.
  - req_sub[i]=0 computes A+B.
- ADDER_ARB_SUB_EN undefined:
  - req_sub is ignored, all operations are A+B, and no inverter or carry-in logic is built.
  - The port remains present in both builds.

## Test plan
- Reset then idle: rst=1 for 2 cycles, no requests → all outputs 0, req_ready=0, op_count=0.
- Single add: req 0 with A=100, B=200, resp_ready=1 → req_ready=4'b0001 in cycle N; in cycle N+1, resp_valid=1, resp_id=0, resp_result=300, resp_carry=0.
- Carry and wrap: A=32'hFFFF_FFFF, B=1 → resp_result=0, resp_carry=1. With ADDER_ARB_SUB_EN: A=5, B=7, sub=1 → result 32'hFFFF_FFFE, carry=0.
- Round-robin fairness:
  - Stimulus: all 4 requesters held valid, resp_ready=1 for 8 cycles.
  - Required: resp_id sequence 0,1,2,3,0,1,2,3; op_count=8.
- Backpressure: resp_ready=0 for 3 cycles with requesters 1 and 2 pending → req_ready=0 and resp_* stable. On resp_ready=1, the next accept is back-to-back in the same cycle.
- Reset mid-stream: assert rst while resp_valid=1 and requests are pending → next cycle resp_valid=0, ptr=0, op_count=0, and the first grant after reset goes to requester 0.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin arbiter time-sharing one adder among NUM_REQ requesters
// Optional feature macro: ADDER_ARB_SUB_EN (per-requester subtract via req_sub).
module adder_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_sub,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [IDW-1:0]           resp_id,
  output logic [WIDTH-1:0]         resp_result,
  output logic                     resp_carry,
  output logic [15:0]              op_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

  slot_state_t      state_q;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic [15:0]      op_count_q;

  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] b_arr [NUM_REQ];
  logic [IDW-1:0]   cand_idx [NUM_REQ];
  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic             accept;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic             sub_sel;
  logic [WIDTH:0]   sum;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Candidate order starting at the round-robin pointer, wrapping modulo NUM_REQ.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_idx[k] = IDW'((int'(ptr_q) + k) % NUM_REQ);
    end
  end

  // First valid requester in candidate order wins; scan backwards so the earliest match sticks.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[cand_idx[k]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
  end

  // Accept whenever the slot is free or being drained this cycle; never while in reset.
  assign accept = grant_found && ((state_q == EMPTY) || resp_ready) && !rst;

  // One-hot accept strobe back to the winning requester.
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign a_sel   = a_arr[grant_idx];
  assign b_sel   = b_arr[grant_idx];
  assign sub_sel = req_sub[grant_idx];

`ifdef ADDER_ARB_SUB_EN
  logic [WIDTH-1:0] b_eff;
  assign b_eff = sub_sel ? ~b_sel : b_sel;
  assign sum   = {1'b0, a_sel} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_sel};
`else
  logic unused_sub;
  assign unused_sub = sub_sel;
  assign sum        = {1'b0, a_sel} + {1'b0, b_sel};
`endif

  // Pointer moves to just past the winner so it becomes lowest priority next time.
  assign ptr_d = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // Response slot FSM: capture on accept, empty on drain with no new accept, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      ptr_q      <= '0;
      id_q       <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      op_count_q <= '0;
    end else if (accept) begin
      state_q    <= FULL;
      ptr_q      <= ptr_d;
      id_q       <= grant_idx;
      result_q   <= sum[WIDTH-1:0];
      carry_q    <= sum[WIDTH];
      op_count_q <= op_count_q + 16'd1;
    end else if ((state_q == FULL) && resp_ready) begin
      state_q    <= EMPTY;
    end
  end

  assign resp_valid  = (state_q == FULL);
  assign resp_id     = id_q;
  assign resp_result = result_q;
  assign resp_carry  = carry_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - scoreboard bench for adder_share_arbiter (NUM_REQ=4, WIDTH=32)
module tb_adder_share_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]   req_sub;
  logic              resp_valid;
  logic              resp_ready;
  logic [1:0]        resp_id;
  logic [WIDTH-1:0]  resp_result;
  logic              resp_carry;
  logic [15:0]       op_count;

  adder_share_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result), .resp_carry(resp_carry),
    .op_count(op_count)
  );

  typedef struct {
    logic [1:0]       id;
    logic [WIDTH-1:0] result;
    logic             carry;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_count = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic void push(input logic [1:0] id, input logic [WIDTH-1:0] res, input logic c);
    exp_t e;
    e.id = id; e.result = res; e.carry = c;
    exp_q.push_back(e);
    exp_count++;
  endfunction

  // Monitor: every consumed response is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 64'(resp_id), 64'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_id", 64'(resp_id), 64'(e.id));
        chk("resp_result", 64'(resp_result), 64'(e.result));
        chk("resp_carry", 64'(resp_carry), 64'(e.carry));
      end
    end
  end

  // One clock with inputs already driven: check req_ready mid-cycle, then advance past the edge.
  task automatic step(input logic [NREQ-1:0] exp_ready, input string name);
    @(negedge clk);
    chk(name, 64'(req_ready), 64'(exp_ready));
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_sub[i] = s;
  endtask

  logic [WIDTH-1:0] fair_res [NREQ] = '{32'd11, 32'd22, 32'd33, 32'd44};

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; resp_ready = 1'b0;

    // Reset then idle; req_ready must stay low while rst=1 even with requests present
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'b1111;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_resp_valid", 64'(resp_valid), 64'h0);
    chk("rst_resp_id", 64'(resp_id), 64'h0);
    chk("rst_resp_result", 64'(resp_result), 64'h0);
    chk("rst_resp_carry", 64'(resp_carry), 64'h0);
    chk("rst_op_count", 64'(op_count), 64'h0);
    @(posedge clk); #1;

    // Single add 100+200
    rst = 1'b0; resp_ready = 1'b1;
    req_valid = 4'b0001; set_op(0, 32'd100, 32'd200, 1'b0);
    push(2'd0, 32'd300, 1'b0);
    step(4'b0001, "single_ready");
    req_valid = '0;
    step(4'b0000, "single_drain");
    chk("single_op_count", 64'(op_count), 64'd1);

    // Carry out and wrap (ptr=1, so requester 0 is found after wrapping)
    req_valid = 4'b0001; set_op(0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    push(2'd0, 32'h0, 1'b1);
    step(4'b0001, "carry_ready");
    req_valid = '0;
    step(4'b0000, "carry_drain");

`ifdef ADDER_ARB_SUB_EN
    req_valid = 4'b0001; set_op(0, 32'd5, 32'd7, 1'b1);
    push(2'd0, 32'hFFFF_FFFE, 1'b0);
`else
    req_valid = 4'b0001; set_op(0, 32'd5, 32'd7, 1'b1);
    push(2'd0, 32'd12, 1'b0);
`endif
    step(4'b0001, "sub_ready");
    req_valid = '0; req_sub = '0;
    step(4'b0000, "sub_drain");

    // Lone requester 3 with ptr=1
    req_valid = 4'b1000; set_op(3, 32'd40, 32'd4, 1'b0);
    push(2'd3, 32'd44, 1'b0);
    step(4'b1000, "rot_ready");
    req_valid = '0;
    step(4'b0000, "rot_drain");
    chk("pre_fair_op_count", 64'(op_count), 64'(exp_count));

    // Reset before fairness so the sequence starts at requester 0 and op_count at 0
    rst = 1'b1;
    step(4'b0000, "rst2_ready");
    rst = 1'b0; exp_q.delete(); exp_count = 0;

    // Round-robin fairness: all four held valid for 8 cycles
    set_op(0, 32'd10, 32'd1, 1'b0);
    set_op(1, 32'd20, 32'd2, 1'b0);
    set_op(2, 32'd30, 32'd3, 1'b0);
    set_op(3, 32'd40, 32'd4, 1'b0);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      push(2'(k % 4), fair_res[k % 4], 1'b0);
      step(4'(1 << (k % 4)), "fair_ready");
    end
    req_valid = '0;
    step(4'b0000, "fair_drain");
    chk("fair_op_count", 64'(op_count), 64'd8);

    // Backpressure with requesters 1 and 2 pending
    resp_ready = 1'b0; req_valid = 4'b0110;
    push(2'd1, 32'd22, 1'b0);
    step(4'b0010, "bp_fill");
    for (int k = 0; k < 3; k++) begin
      step(4'b0000, "bp_ready");
      chk("bp_valid", 64'(resp_valid), 64'h1);
      chk("bp_id", 64'(resp_id), 64'd1);
      chk("bp_result", 64'(resp_result), 64'd22);
    end
    resp_ready = 1'b1;
    push(2'd2, 32'd33, 1'b0);
    step(4'b0100, "bp_release");
    push(2'd1, 32'd22, 1'b0);
    step(4'b0010, "bp_next");
    req_valid = '0;
    step(4'b0000, "bp_drain");
    chk("bp_op_count", 64'(op_count), 64'd11);

    // Reset mid-stream: slot full with requests pending
    resp_ready = 1'b0; req_valid = 4'b1111;
    step(4'b0100, "mid_fill");
    chk("mid_valid_before", 64'(resp_valid), 64'h1);
    rst = 1'b1;
    step(4'b0000, "mid_rst_ready");
    exp_q.delete(); exp_count = 0;
    chk("mid_resp_valid", 64'(resp_valid), 64'h0);
    chk("mid_op_count", 64'(op_count), 64'h0);
    chk("mid_resp_result", 64'(resp_result), 64'h0);
    rst = 1'b0; resp_ready = 1'b1;
    push(2'd0, 32'd11, 1'b0);
    step(4'b0001, "post_rst_grant");
    req_valid = '0;
    step(4'b0000, "post_rst_drain");
    chk("post_rst_op_count", 64'(op_count), 64'd1);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
